output_router_ctrl: RTL and testbench

- Sequencer for the output router between the PE array output row and the output scratchpad.
- Per output vector it waits for PE results, pulses the router enable to capture them, then steps through the router's packed groups one per scratchpad write.
- Generates the scratchpad write address and write strobe, and signals completion after a programmed number of vectors.
- Handles scratchpad back-pressure through a ready input.

---
 rtl/output_router_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_output_router_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_router_ctrl.sv
// ---------------------------------------------------------------------------
// output_router_ctrl
//
// Sequencer between the PE array output row and the output scratchpad.
// For every output vector it waits for PE results, pulses the router enable
// and PE acknowledge to capture them, then writes the router's packed groups
// to the scratchpad, one group per accepted write. After the programmed
// number of vectors it pulses o_done and returns to idle.
//
// Configuration macro:
//   OUT_ROUTER_SKIP_EMPTY_EN - when defined, groups whose lanes are all
//   invalid in the captured mask are skipped. Each vector then ends after
//   its highest non-empty group. When undefined, every group is written.
//
// Ports:
//   i_clk         clock, rising edge
//   i_nrst        synchronous active-low reset
//   i_start       one-cycle job start, honoured only in IDLE
//   i_base_addr   first scratchpad write address, latched on start
//   i_vec_cnt     number of vectors to drain, latched on start
//   i_valid       per-lane PE result valid (bit i = lane i)
//   i_spad_ready  scratchpad accepts a write this cycle
//   o_router_en   one-cycle capture pulse to the output router
//   o_pe_ack      one-cycle acknowledge to the PEs, same cycle as o_router_en
//   o_group_sel   router group currently being written
//   o_spad_addr   scratchpad write address
//   o_spad_we     scratchpad write strobe
//   o_busy        high whenever a job is in progress
//   o_done        one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module output_router_ctrl #(
  parameter int SPAD_ADDR_WIDTH = 8,
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int ROUTER_COUNT    = 5,
  parameter int DATA_WIDTH      = 8,
  parameter int MEMBER_CNT      = (SPAD_DATA_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
  parameter int GROUP_CNT       = (ROUTER_COUNT + MEMBER_CNT - 1) / MEMBER_CNT,
  parameter int CNT_WIDTH       = 8,
  localparam int GSEL_WIDTH     = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_start,
  input  logic [SPAD_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]       i_vec_cnt,
  input  logic [ROUTER_COUNT-1:0]    i_valid,
  input  logic                       i_spad_ready,
  output logic                       o_router_en,
  output logic                       o_pe_ack,
  output logic [GSEL_WIDTH-1:0]      o_group_sel,
  output logic [SPAD_ADDR_WIDTH-1:0] o_spad_addr,
  output logic                       o_spad_we,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [SPAD_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [GSEL_WIDTH-1:0]        group_q, group_d;
  logic [CNT_WIDTH-1:0]         remain_q, remain_d;
  logic                         router_en_q, router_en_d;

  // Group bookkeeping shared by the sequencing logic below
  logic                         last_group;
  logic [GSEL_WIDTH-1:0]        next_group;
  logic [GSEL_WIDTH-1:0]        first_group;

`ifdef OUT_ROUTER_SKIP_EMPTY_EN
  // The captured lane mask decides which groups carry data for this vector
  logic [ROUTER_COUNT-1:0]      mask_q, mask_d;
  logic [GROUP_CNT-1:0]         mask_hits;
  logic [GROUP_CNT-1:0]         higher_hits;

  // Bit g set when at least one lane of group g is valid
  function automatic logic [GROUP_CNT-1:0] group_hits(input logic [ROUTER_COUNT-1:0] mask);
    group_hits = '0;
    for (int lane = 0; lane < ROUTER_COUNT; lane++) begin
      if (mask[lane]) begin
        group_hits[lane / MEMBER_CNT] = 1'b1;
      end
    end
  endfunction

  // Lowest non-empty group index at or above 'from'
  function automatic logic [GSEL_WIDTH-1:0] lowest_from(input logic [GROUP_CNT-1:0] hits,
                                                        input int from);
    lowest_from = '0;
    for (int k = GROUP_CNT - 1; k >= 0; k--) begin
      if (hits[k] && (k >= from)) begin
        lowest_from = GSEL_WIDTH'(k);
      end
    end
  endfunction

  assign mask_hits   = group_hits(mask_q);
  assign higher_hits = mask_hits >> group_q;
  // Current group is the last one when no non-empty group lies above it
  assign last_group  = ((higher_hits >> 1) == '0);
  assign next_group  = lowest_from(mask_hits, int'(group_q) + 1);
  // i_valid is non-zero whenever this is used, so a non-empty group exists
  assign first_group = lowest_from(group_hits(i_valid), 0);
`else
  // Without skipping the mask has no effect on sequencing, so it is not kept
  localparam logic [GSEL_WIDTH-1:0] LAST_GROUP = GSEL_WIDTH'(GROUP_CNT - 1);

  assign last_group  = (group_q == LAST_GROUP);
  assign next_group  = group_q + 1'b1;
  assign first_group = '0;
`endif

  // Next-state and datapath logic. A write is accepted on any DRAIN cycle
  // with ready high since the write strobe is decoded from DRAIN alone.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    group_d     = group_q;
    remain_d    = remain_q;
    router_en_d = 1'b0;
`ifdef OUT_ROUTER_SKIP_EMPTY_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d   = i_base_addr;
          remain_d = i_vec_cnt;
          state_d  = (i_vec_cnt == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_valid != '0) begin
`ifdef OUT_ROUTER_SKIP_EMPTY_EN
          mask_d      = i_valid;
`endif
          group_d     = first_group;
          router_en_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_spad_ready) begin
          addr_d = addr_q + 1'b1;
          if (last_group) begin
            remain_d = remain_q - 1'b1;
            group_d  = '0;
            state_d  = (remain_q == CNT_WIDTH'(1)) ? S_DONE : S_WAIT;
          end else begin
            group_d = next_group;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job without o_done
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      group_q     <= '0;
      remain_q    <= '0;
      router_en_q <= 1'b0;
`ifdef OUT_ROUTER_SKIP_EMPTY_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      group_q     <= group_d;
      remain_q    <= remain_d;
      router_en_q <= router_en_d;
`ifdef OUT_ROUTER_SKIP_EMPTY_EN
      mask_q      <= mask_d;
`endif
    end
  end

  // Outputs come only from registers or decoded registered state
  assign o_router_en = router_en_q;
  assign o_pe_ack    = router_en_q;
  assign o_group_sel = group_q;
  assign o_spad_addr = addr_q;
  assign o_spad_we   = (state_q == S_DRAIN);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_output_router_ctrl.sv
// ---------------------------------------------------------------------------
// tb_output_router_ctrl
//
// Self-checking bench for output_router_ctrl with default parameters
// (5 lanes, 2 lanes per word, 3 groups). Each job's expected scratchpad
// writes are pushed to a scoreboard queue when the job is started; a
// negedge monitor pops and compares every accepted write.
// ---------------------------------------------------------------------------
module tb_output_router_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic [7:0] base;
  logic [7:0] vcnt;
  logic [4:0] valid;
  logic       ready;

  logic       o_router_en;
  logic       o_pe_ack;
  logic [1:0] o_group_sel;
  logic [7:0] o_spad_addr;
  logic       o_spad_we;
  logic       o_busy;
  logic       o_done;

  output_router_ctrl dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_start      (start),
    .i_base_addr  (base),
    .i_vec_cnt    (vcnt),
    .i_valid      (valid),
    .i_spad_ready (ready),
    .o_router_en  (o_router_en),
    .o_pe_ack     (o_pe_ack),
    .o_group_sel  (o_group_sel),
    .o_spad_addr  (o_spad_addr),
    .o_spad_we    (o_spad_we),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] grp;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int wr_cnt, ren_cnt, done_cnt, last_wr_cycle, done_cycle;

  // Free-running cycle index, advanced on every rising edge
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: counts pulses and compares every accepted write to the scoreboard
  always @(negedge clk) begin
    if (nrst) begin
      if (o_router_en) ren_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cycle = cycle;
      end
      if (o_spad_we && ready) begin
        wr_cnt++;
        last_wr_cycle = cycle;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%02h grp=%0d, expected no write",
                   o_spad_addr, o_group_sel);
        end else begin
          mon_exp = exp_q.pop_front();
          if (o_spad_addr !== mon_exp.addr || o_group_sel !== mon_exp.grp) begin
            errors++;
            $display("[TB] FAIL write_data: got addr=%02h grp=%0d, expected addr=%02h grp=%0d",
                     o_spad_addr, o_group_sel, mon_exp.addr, mon_exp.grp);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts;
    wr_cnt        = 0;
    ren_cnt       = 0;
    done_cnt      = 0;
    last_wr_cycle = -1;
    done_cycle    = -1;
  endtask

  // Reference model: expected write sequence for one job, returned count n
  task automatic push_job(input logic [7:0] b, input logic [7:0] cnt,
                          input logic [4:0] m, output int n);
    logic [7:0] a;
    logic [2:0] hits;
    logic       keep;
    wr_t        w;
    a    = b;
    n    = 0;
    hits = {m[4], |m[3:2], |m[1:0]};
    for (int v = 0; v < int'(cnt); v++) begin
      for (int g = 0; g < 3; g++) begin
`ifdef OUT_ROUTER_SKIP_EMPTY_EN
        keep = hits[g];
`else
        keep = 1'b1;
`endif
        if (keep) begin
          w.addr = a;
          w.grp  = 2'(g);
          exp_q.push_back(w);
          a = a + 8'd1;
          n++;
        end
      end
    end
  endtask

  task automatic start_job(input logic [7:0] b, input logic [7:0] cnt, input logic [4:0] m);
    base  = b;
    vcnt  = cnt;
    valid = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_group1(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_spad_we && o_group_sel == 2'd1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Reset state: every output low
  task automatic test_reset;
    nrst  = 1'b0;
    start = 1'b0;
    base  = 8'h00;
    vcnt  = 8'h00;
    valid = 5'h00;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_router_en, o_pe_ack, o_group_sel, o_spad_addr, o_spad_we, o_busy, o_done} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got en=%b ack=%b grp=%0d addr=%02h we=%b busy=%b done=%b, expected all 0",
               o_router_en, o_pe_ack, o_group_sel, o_spad_addr, o_spad_we, o_busy, o_done);
    end
    nrst = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b, expected 0", o_busy);
    end
  endtask

  // Two full vectors with ready held high
  task automatic test_basic;
    int n;
    bit seen;
    clear_counts();
    push_job(8'h10, 8'd2, 5'h1F, n);
    start_job(8'h10, 8'd2, 5'h1F);
    wait_done(60, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL basic_done_timeout: got no o_done, expected o_done within 60 cycles");
    end
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy_fall: got %b, expected 0", o_busy);
    end
    checks++;
    if (done_cycle != last_wr_cycle + 1) begin
      errors++;
      $display("[TB] FAIL basic_done_latency: got done at %0d, expected %0d", done_cycle, last_wr_cycle + 1);
    end
    checks++;
    if (ren_cnt != 2 || wr_cnt != 6 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL basic_counts: got ren=%0d wr=%0d done=%0d, expected 2/6/1", ren_cnt, wr_cnt, done_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_leftover: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  // Stall three cycles at group 1
  task automatic test_back_pressure;
    int n;
    bit seen;
    clear_counts();
    push_job(8'h10, 8'd1, 5'h1F, n);
    start_job(8'h10, 8'd1, 5'h1F);
    wait_group1(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL bp_reach_group1: got timeout, expected group 1 write");
    end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_spad_addr !== 8'h11 || o_spad_we !== 1'b1 || o_group_sel !== 2'd1) begin
        errors++;
        $display("[TB] FAIL bp_hold: got addr=%02h we=%b grp=%0d, expected addr=11 we=1 grp=1",
                 o_spad_addr, o_spad_we, o_group_sel);
      end
      tick();
    end
    ready = 1'b1;
    wait_done(30, seen);
    tick();
    checks++;
    if (!seen || ren_cnt != 1 || wr_cnt != 3 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_counts: got done=%b ren=%0d wr=%0d pending=%0d, expected 1/1/3/0",
               seen, ren_cnt, wr_cnt, exp_q.size());
    end
  endtask

  // Address wraps from 0xFF to 0x00
  task automatic test_wrap;
    int n;
    bit seen;
    clear_counts();
    push_job(8'hFE, 8'd1, 5'h1F, n);
    start_job(8'hFE, 8'd1, 5'h1F);
    wait_done(30, seen);
    tick();
    checks++;
    if (!seen || wr_cnt != 3 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wrap_counts: got done=%b wr=%0d pending=%0d, expected 1/3/0", seen, wr_cnt, exp_q.size());
    end
  endtask

  // Zero vectors: done immediately, no writes or captures
  task automatic test_zero_count;
    clear_counts();
    start_job(8'h33, 8'd0, 5'h1F);
    checks++;
    if (o_done !== 1'b1 || o_spad_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done: got done=%b we=%b, expected done=1 we=0", o_done, o_spad_we);
    end
    tick();
    tick();
    checks++;
    if (wr_cnt != 0 || ren_cnt != 0 || done_cnt != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_counts: got wr=%0d ren=%0d done=%0d busy=%b, expected 0/0/1/0",
               wr_cnt, ren_cnt, done_cnt, o_busy);
    end
  endtask

  // Start during DRAIN must not disturb the running job
  task automatic test_ignored_start;
    int n;
    bit seen;
    clear_counts();
    push_job(8'h40, 8'd2, 5'h1F, n);
    start_job(8'h40, 8'd2, 5'h1F);
    wait_group1(20, seen);
    base  = 8'h80;
    vcnt  = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (o_spad_addr !== 8'h42) begin
      errors++;
      $display("[TB] FAIL ign_start_addr: got %02h, expected 42", o_spad_addr);
    end
    wait_done(60, seen);
    tick();
    checks++;
    if (!seen || wr_cnt != 6 || done_cnt != 1 || exp_q.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ign_start_counts: got done=%b wr=%0d dcnt=%0d pending=%0d busy=%b, expected 1/6/1/0/0",
               seen, wr_cnt, done_cnt, exp_q.size(), o_busy);
    end
  endtask

  // Reset mid-DRAIN aborts the job with no o_done
  task automatic test_reset_mid_drain;
    int n;
    bit seen;
    clear_counts();
    push_job(8'h50, 8'd1, 5'h1F, n);
    start_job(8'h50, 8'd1, 5'h1F);
    wait_group1(20, seen);
    nrst = 1'b0;
    tick();
    checks++;
    if ({o_router_en, o_pe_ack, o_group_sel, o_spad_addr, o_spad_we, o_busy, o_done} !== 15'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got en=%b ack=%b grp=%0d addr=%02h we=%b busy=%b done=%b, expected all 0",
               o_router_en, o_pe_ack, o_group_sel, o_spad_addr, o_spad_we, o_busy, o_done);
    end
    nrst = 1'b1;
    exp_q.delete();
    repeat (6) tick();
    checks++;
    if (done_cnt != 0 || wr_cnt != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_counts: got done=%0d wr=%0d busy=%b, expected 0/1/0", done_cnt, wr_cnt, o_busy);
    end
  endtask

  // Partial masks: writes depend on whether empty groups are skipped
  task automatic test_skip;
    logic [4:0] masks[5];
    int n;
    bit seen;
    masks[0] = 5'b00011;
    masks[1] = 5'b10000;
    masks[2] = 5'b00100;
    masks[3] = 5'b01100;
    masks[4] = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      clear_counts();
      push_job(8'h20, 8'd2, masks[i], n);
      start_job(8'h20, 8'd2, masks[i]);
      wait_done(60, seen);
      tick();
      checks++;
      if (!seen || wr_cnt != n || ren_cnt != 2 || exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL skip_mask_%05b: got done=%b wr=%0d ren=%0d pending=%0d, expected 1/%0d/2/0",
                 masks[i], seen, wr_cnt, ren_cnt, exp_q.size(), n);
      end
    end
  endtask

  // Several vectors with random back-pressure
  task automatic test_back_to_back;
    int n;
    bit seen;
    clear_counts();
    push_job(8'hF0, 8'd4, 5'b01010, n);
    base  = 8'hF0;
    vcnt  = 8'd4;
    valid = 5'b01010;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    tick();
    checks++;
    if (!seen || wr_cnt != n || ren_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got done=%b wr=%0d ren=%0d pending=%0d, expected 1/%0d/4/0",
               seen, wr_cnt, ren_cnt, exp_q.size(), n);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap();
    test_zero_count();
    test_ignored_start();
    test_reset_mid_drain();
    test_skip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
